// File: rtl/ro_freq_counter.sv
// ro_freq_counter: enables the ring oscillator, synchronizes its output and counts
// rising edges over a fixed clk window after a settle period.
module ro_freq_counter #(
    parameter int WINDOW_CYCLES = 1000,
    parameter int SETTLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_out,
    output logic             ro_en,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             overflow
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] COUNT  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam int TW = $clog2((WINDOW_CYCLES > SETTLE_CYCLES ? WINDOW_CYCLES : SETTLE_CYCLES) + 1);

    logic [1:0]             r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_sat;
    logic                   r_ro_en;
    logic                   r_valid;
    logic                   r_overflow;
    logic [TW-1:0]          r_timer;
    logic [CNT_W-1:0]       r_edges;
    logic [CNT_W-1:0]       r_count;
    logic                   w_rise;
    logic                   w_count_rise;
    logic                   w_at_max;
    logic                   w_settle_end;
    logic                   w_count_end;
    logic                   w_sat_next;
    logic [CNT_W-1:0]       w_edges_next;

    assign w_rise       = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_count_rise = (r_state == COUNT) & w_rise;
    assign w_at_max     = &r_edges;
    assign w_settle_end = r_timer == TW'(SETTLE_CYCLES - 1);
    assign w_count_end  = r_timer == TW'(WINDOW_CYCLES - 1);
    // Saturate rather than wrap; the sticky flag records any rise lost at the ceiling.
    assign w_edges_next = (w_count_rise && !w_at_max) ? r_edges + CNT_W'(1) : r_edges;
    assign w_sat_next   = r_sat | (w_count_rise & w_at_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sync     <= '0;
            r_hist     <= 1'b0;
            r_sat      <= 1'b0;
            r_ro_en    <= 1'b0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_timer    <= '0;
            r_edges    <= '0;
            r_count    <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], ro_out};
            r_hist  <= r_sync[SYNC_STAGES-1];
            r_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_state <= SETTLE;
                    r_ro_en <= 1'b1;
                    r_timer <= '0;
                    r_edges <= '0;
                    r_sat   <= 1'b0;
                end
            end else if (r_state == SETTLE) begin
                r_timer <= w_settle_end ? '0 : r_timer + TW'(1);
                r_state <= w_settle_end ? COUNT : SETTLE;
            end else if (r_state == COUNT) begin
                r_edges <= w_edges_next;
                r_sat   <= w_sat_next;
                r_timer <= r_timer + TW'(1);
                if (w_count_end) begin
                    r_state    <= DONE;
                    r_ro_en    <= 1'b0;
                    r_valid    <= 1'b1;
                    r_count    <= w_edges_next;
                    r_overflow <= w_sat_next;
                end
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign ro_en    = r_ro_en;
    assign busy     = r_state != IDLE;
    assign count    = r_count;
    assign valid    = r_valid;
    assign overflow = r_overflow;
endmodule
